// File: rtl/bids22_round_seq_pkg.sv
// bids22_seq_pkg: shared definitions for the bids22 round sequencer.
//   opcode_e     - 4-bit bids22 core opcode encoding (NoOp..BidCharge)
//   ERR_*        - seq_err codes
//   state_t/ST_* - sequencer FSM state encoding
//   cmd_t        - 36-bit command FIFO entry {op, data}
//   DEFAULT_KEY  - default Lock/Unlock key
package bids22_seq_pkg;

  typedef enum logic [3:0] {
    OP_NOOP       = 4'd0,
    OP_UNLOCK     = 4'd1,
    OP_LOCK       = 4'd2,
    OP_LOADX      = 4'd3,
    OP_LOADY      = 4'd4,
    OP_LOADZ      = 4'd5,
    OP_SETXYZMASK = 4'd6,
    OP_SETTIMER   = 4'd7,
    OP_BIDCHARGE  = 4'd8
  } opcode_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_RESERVED = 2'b01;
  localparam logic [1:0] ERR_INVALID  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_ISSUE    = 3'd1;
  localparam state_t ST_LOCK     = 3'd2;
  localparam state_t ST_RUN      = 3'd3;
  localparam state_t ST_WAIT_RES = 3'd4;
  localparam state_t ST_UNLOCK   = 3'd5;

  localparam logic [31:0] DEFAULT_KEY = 32'h0F0F_0F0F;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] data;
  } cmd_t;

  // Host may pass NoOp and the configuration opcodes straight through;
  // Lock/Unlock are reserved for the sequencer itself.
  function automatic logic op_issuable(input logic [3:0] op);
    return (op == OP_NOOP) || ((op >= OP_LOADX) && (op <= OP_BIDCHARGE));
  endfunction

endpackage

// File: rtl/bids22_round_seq_if.sv
// bids22_round_seq_if: host command push channel.
//   cmd_valid - host command valid
//   cmd_ready - sequencer can accept (FIFO not full)
//   cmd_op    - 4-bit opcode
//   cmd_data  - 32-bit operand
// master = host side, slave = sequencer side.
interface bids22_round_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/bids22_cmd_fifo.sv
// bids22_cmd_fifo: synchronous FIFO for host commands.
//   clk, reset - clock, synchronous active-high reset (flushes pointers)
//   push, din  - write request/data; ignored when full
//   pop, dout  - read request/head entry; ignored when empty
//   full/empty - occupancy flags
// A pushed entry is visible at dout the cycle after the push.
module bids22_cmd_fifo
  import bids22_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = $bits(cmd_t)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/bids22_round_seq.sv
// bids22_round_seq: command sequencer feeding the bids22 auction core.
// Host commands are queued in a FIFO and issued one per opcode cycle when
// the core is ready; a go request runs Lock -> C_start window -> wait for
// roundOver (with timeout) -> Unlock.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   cmd (slave)     - host push channel: cmd_valid/cmd_ready/cmd_op/cmd_data
//   go              - single-cycle round request
//   core_ready      - core can accept an opcode
//   core_roundOver  - core finished the round
//   abort           - (BIDS22_SEQ_ABORT_EN only) end the C_start window early
//   C_op/C_data     - opcode/operand to the core (NoOp/0 when idle)
//   C_start         - round-active to the core
//   busy            - FSM active or round pending
//   round_done      - pulse in the Unlock cycle
//   rounds_cnt      - completed rounds, saturating
//   seq_err         - sticky last error code
// Optional feature macro: BIDS22_SEQ_ABORT_EN.
module bids22_round_seq
  import bids22_seq_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned ROUND_CYCLES   = 16,
  parameter logic [31:0] KEY            = DEFAULT_KEY,
  parameter int unsigned RESULT_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  bids22_round_seq_if.slave   cmd,
  input  logic                go,
  input  logic                core_ready,
  input  logic                core_roundOver,
`ifdef BIDS22_SEQ_ABORT_EN
  input  logic                abort,
`endif
  output logic [3:0]          C_op,
  output logic [31:0]         C_data,
  output logic                C_start,
  output logic                busy,
  output logic                round_done,
  output logic [15:0]         rounds_cnt,
  output logic [1:0]          seq_err
);

  localparam int unsigned WW = (RESULT_TIMEOUT > 1) ? $clog2(RESULT_TIMEOUT) : 1;

  state_t         state, state_n;
  logic           go_pending, go_pending_n;
  logic [31:0]    shadow, shadow_n;
  logic [31:0]    run_cnt, run_cnt_n;
  logic [WW-1:0]  wait_cnt, wait_cnt_n;
  logic [3:0]     c_op_n;
  logic [31:0]    c_data_n;
  logic           c_start_n;
  logic           busy_n;
  logic           round_done_n;
  logic [15:0]    rounds_n;
  logic [1:0]     seq_err_n;

  cmd_t           fifo_din, head;
  logic           fifo_pop, fifo_full, fifo_empty;
  logic           abort_req;

`ifdef BIDS22_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign fifo_din      = {cmd.cmd_op, cmd.cmd_data};
  assign cmd.cmd_ready = !fifo_full;

  bids22_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd.cmd_valid),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Outputs are registered from next-state values, so the opcode belonging
  // to ISSUE/LOCK/UNLOCK is computed on the transition into that state.
  always_comb begin
    state_n      = state;
    go_pending_n = go_pending | go;
    shadow_n     = shadow;
    run_cnt_n    = run_cnt;
    wait_cnt_n   = wait_cnt;
    c_op_n       = OP_NOOP;
    c_data_n     = '0;
    c_start_n    = 1'b0;
    round_done_n = 1'b0;
    rounds_n     = rounds_cnt;
    seq_err_n    = seq_err;
    fifo_pop     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty && core_ready) begin
          fifo_pop = 1'b1;
          state_n  = ST_ISSUE;
          if (op_issuable(head.op)) begin
            c_op_n   = head.op;
            c_data_n = head.data;
            if (head.op == OP_SETTIMER)
              shadow_n = (head.data == '0) ? 32'd1 : head.data;
          end else if ((head.op == OP_LOCK) || (head.op == OP_UNLOCK)) begin
            seq_err_n = ERR_RESERVED;
          end else begin
            seq_err_n = ERR_INVALID;
          end
        end else if (go_pending_n && fifo_empty && core_ready) begin
          state_n      = ST_LOCK;
          c_op_n       = OP_LOCK;
          c_data_n     = KEY;
          go_pending_n = 1'b0;
          seq_err_n    = ERR_NONE;
        end
      end
      ST_ISSUE: state_n = ST_IDLE;
      ST_LOCK: begin
        state_n   = ST_RUN;
        c_start_n = 1'b1;
        run_cnt_n = shadow;
      end
      ST_RUN: begin
        // run_cnt holds the cycles left including the current one.
        if ((run_cnt == 32'd1) || abort_req) begin
          state_n    = ST_WAIT_RES;
          wait_cnt_n = '0;
        end else begin
          c_start_n = 1'b1;
          run_cnt_n = run_cnt - 32'd1;
        end
      end
      ST_WAIT_RES: begin
        if (core_roundOver || (wait_cnt == WW'(RESULT_TIMEOUT - 1))) begin
          if (!core_roundOver) seq_err_n = ERR_TIMEOUT;
          state_n      = ST_UNLOCK;
          c_op_n       = OP_UNLOCK;
          c_data_n     = KEY;
          round_done_n = 1'b1;
          if (rounds_cnt != '1) rounds_n = rounds_cnt + 16'd1;
        end else begin
          wait_cnt_n = wait_cnt + WW'(1);
        end
      end
      ST_UNLOCK: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase

    busy_n = (state_n != ST_IDLE) || go_pending_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      go_pending <= 1'b0;
      shadow     <= 32'(ROUND_CYCLES);
      run_cnt    <= '0;
      wait_cnt   <= '0;
      C_op       <= '0;
      C_data     <= '0;
      C_start    <= 1'b0;
      busy       <= 1'b0;
      round_done <= 1'b0;
      rounds_cnt <= '0;
      seq_err    <= ERR_NONE;
    end else begin
      state      <= state_n;
      go_pending <= go_pending_n;
      shadow     <= shadow_n;
      run_cnt    <= run_cnt_n;
      wait_cnt   <= wait_cnt_n;
      C_op       <= c_op_n;
      C_data     <= c_data_n;
      C_start    <= c_start_n;
      busy       <= busy_n;
      round_done <= round_done_n;
      rounds_cnt <= rounds_n;
      seq_err    <= seq_err_n;
    end
  end

endmodule

// File: tb/tb_bids22_round_seq.sv
// Testbench for bids22_round_seq: directed steps plus randomized command
// batches checked against a transaction-level model of the issue stream.
module tb_bids22_round_seq;

  localparam logic [31:0] KEY = 32'h0F0F_0F0F;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic        core_ready;
  logic        core_roundOver;
  logic [3:0]  C_op;
  logic [31:0] C_data;
  logic        C_start;
  logic        busy;
  logic        round_done;
  logic [15:0] rounds_cnt;
  logic [1:0]  seq_err;

  bids22_round_seq_if cif();

  bids22_round_seq #(
    .DEPTH          (8),
    .ROUND_CYCLES   (16),
    .KEY            (KEY),
    .RESULT_TIMEOUT (255)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd            (cif),
    .go             (go),
    .core_ready     (core_ready),
    .core_roundOver (core_roundOver),
    .C_op           (C_op),
    .C_data         (C_data),
    .C_start        (C_start),
    .busy           (busy),
    .round_done     (round_done),
    .rounds_cnt     (rounds_cnt),
    .seq_err        (seq_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [35:0] obs_q[$];
  logic [35:0] exp_q[$];

  // model state
  int          m_timer  = 16;
  int          m_rounds = 0;
  int          m_err    = 0;

  // per-run observations
  int cs_cnt, rd_cnt, rise_idx, fall_idx, unlock_idx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_obs(input string tag);
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk({tag, "_cmd"}, 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  // Reference behaviour of one queued host command.
  function automatic void model_cmd(input int op, input logic [31:0] data);
    if (op >= 3 && op <= 8) begin
      exp_q.push_back({4'(op), data});
      if (op == 7) m_timer = (data == 0) ? 1 : int'(data);
    end else if (op == 1 || op == 2) begin
      m_err = 1;
    end else if (op != 0) begin
      m_err = 2;
    end
  endfunction

  function automatic void model_round();
    exp_q.push_back({4'd2, KEY});
    exp_q.push_back({4'd1, KEY});
    if (m_rounds < 16'hFFFF) m_rounds++;
  endfunction

  task automatic push(input logic [3:0] op, input logic [31:0] data, output bit acc);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_data  = data;
    acc           = cif.cmd_ready;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
  endtask

  // Run n cycles, recording the core-side stream; roundOver is pulsed
  // ro_delay cycles after C_start falls (never if ro_delay < 0).
  task automatic run(input int n, input int ro_delay);
    int  since = -1;
    bit  prev_cs = 1'b0;
    cs_cnt = 0; rd_cnt = 0; rise_idx = -1; fall_idx = -1; unlock_idx = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      go = 1'b0;
      if (C_op != 4'd0) obs_q.push_back({C_op, C_data});
      if (C_op == 4'd1 && unlock_idx < 0) unlock_idx = i;
      if (C_start) cs_cnt++;
      if (round_done) rd_cnt++;
      if (C_start && !prev_cs && rise_idx < 0) rise_idx = i;
      if (!C_start && prev_cs) begin
        fall_idx = i;
        since = 0;
      end else if (since >= 0) begin
        since++;
      end
      core_roundOver = (ro_delay >= 0 && since == ro_delay);
      prev_cs = C_start;
    end
    core_roundOver = 1'b0;
  endtask

  initial begin
    bit acc;
    int n, op, d;
    logic [31:0] data;

    reset = 1'b1; go = 1'b0; core_ready = 1'b0; core_roundOver = 1'b0;
    cif.cmd_valid = 1'b0; cif.cmd_op = '0; cif.cmd_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset values
    chk("rst_C_op", 64'(C_op), 0);
    chk("rst_C_data", 64'(C_data), 0);
    chk("rst_C_start", 64'(C_start), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_round_done", 64'(round_done), 0);
    chk("rst_rounds_cnt", 64'(rounds_cnt), 0);
    chk("rst_seq_err", 64'(seq_err), 0);
    chk("rst_cmd_ready", 64'(cif.cmd_ready), 1);

    // reset in the middle of RUN
    core_ready = 1'b1;
    go = 1'b1;
    exp_q.push_back({4'd2, KEY});
    run(6, 0);
    compare_obs("midrst_lock");
    chk("midrst_busy", 64'(busy), 1);
    chk("midrst_cstart_on", 64'(C_start), 1);
    push(4'd3, 32'h11, acc);
    push(4'd4, 32'h22, acc);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_cstart_off", 64'(C_start), 0);
    chk("midrst_rounds", 64'(rounds_cnt), 0);
    chk("midrst_busy_off", 64'(busy), 0);
    reset = 1'b0;
    run(20, 0);
    compare_obs("midrst_no_issue");
    chk("midrst_rounds_after", 64'(rounds_cnt), 0);
    m_timer = 16;

    // LoadX + SetTimer then a round, roundOver 3 cycles after C_start falls
    core_ready = 1'b0;
    push(4'd3, 32'd1000, acc); model_cmd(3, 32'd1000);
    push(4'd7, 32'd5, acc);    model_cmd(7, 32'd5);
    core_ready = 1'b1;
    go = 1'b1;
    model_round(); m_err = 0;
    run(60, 3);
    compare_obs("main");
    chk("main_cstart_cycles", 64'(cs_cnt), 64'(m_timer));
    chk("main_cstart_window", 64'(fall_idx - rise_idx), 64'(m_timer));
    chk("main_unlock_lat", 64'(unlock_idx - fall_idx), 4);
    chk("main_round_done", 64'(rd_cnt), 1);
    chk("main_rounds", 64'(rounds_cnt), 64'(m_rounds));
    chk("main_seq_err", 64'(seq_err), 0);
    chk("main_busy", 64'(busy), 0);

    // reserved and invalid opcodes are dropped, go clears the error
    core_ready = 1'b0;
    push(4'd2, 32'h55, acc); model_cmd(2, 32'h55);
    core_ready = 1'b1;
    run(6, -1);
    compare_obs("err_res");
    chk("err_reserved", 64'(seq_err), 64'(m_err));
    core_ready = 1'b0;
    push(4'd12, 32'h66, acc); model_cmd(12, 32'h66);
    core_ready = 1'b1;
    run(6, -1);
    compare_obs("err_inv");
    chk("err_invalid", 64'(seq_err), 64'(m_err));
    go = 1'b1;
    model_round(); m_err = 0;
    run(60, 0);
    compare_obs("err_round");
    chk("err_cleared", 64'(seq_err), 0);
    chk("err_unlock_lat", 64'(unlock_idx - fall_idx), 1);
    chk("err_rounds", 64'(rounds_cnt), 64'(m_rounds));

    // result timeout
    go = 1'b1;
    model_round(); m_err = 3;
    run(320, -1);
    compare_obs("tmo");
    chk("tmo_seq_err", 64'(seq_err), 64'(m_err));
    chk("tmo_wait", 64'(unlock_idx - fall_idx), 255);
    chk("tmo_round_done", 64'(rd_cnt), 1);
    chk("tmo_rounds", 64'(rounds_cnt), 64'(m_rounds));

    // FIFO full: 9 pushes while stalled, only 8 stored
    core_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      data = $urandom;
      push(4'(3 + i % 4), data, acc);
      chk("full_accept", 64'(acc), (i < 8) ? 64'd1 : 64'd0);
      if (i < 8) model_cmd(3 + i % 4, data);
    end
    chk("full_ready", 64'(cif.cmd_ready), 0);
    core_ready = 1'b1;
    run(30, -1);
    compare_obs("full_drain");
    chk("full_ready_after", 64'(cif.cmd_ready), 1);

    // randomized command batches followed by a round
    for (int it = 0; it < 6; it++) begin
      core_ready = 1'b0;
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        op   = $urandom_range(0, 15);
        data = (op == 7) ? 32'($urandom_range(0, 6)) : $urandom;
        push(4'(op), data, acc);
        model_cmd(op, data);
      end
      core_ready = 1'b1;
      run(2 * n + 4, -1);
      compare_obs("rnd_cmds");
      chk("rnd_err_pre", 64'(seq_err), 64'(m_err));
      d = $urandom_range(0, 5);
      go = 1'b1;
      model_round(); m_err = 0;
      run(m_timer + d + 30, d);
      compare_obs("rnd_round");
      chk("rnd_cstart", 64'(cs_cnt), 64'(m_timer));
      chk("rnd_unlock_lat", 64'(unlock_idx - fall_idx), 64'(d + 1));
      chk("rnd_rounds", 64'(rounds_cnt), 64'(m_rounds));
      chk("rnd_err_post", 64'(seq_err), 64'(m_err));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
